// File: rtl/keypad_entry_if.sv
// Keypad entry bus: one-hot scan code toward the engine, BCD number and key/entry strobes back.
// The scanner side uses master; the entry engine uses slave.
interface keypad_entry_if #(
    parameter int DIGITS = 3,
    parameter int CW     = $clog2(DIGITS + 1)
);
    logic [15:0]         onehot;
    logic [4*DIGITS-1:0] bcd;
    logic [CW-1:0]       count;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                entry_valid;
    logic                overflow;

    modport master (
        output onehot,
        input  bcd, count, key_code, key_valid, entry_valid, overflow
    );

    modport slave (
        input  onehot,
        output bcd, count, key_code, key_valid, entry_valid, overflow
    );
endinterface

// File: rtl/keypad_entry.sv
// Keypad digit-entry engine: decodes the one-hot scan, debounces press and release, and edits a BCD number.
// A press is applied DEBOUNCE+1 cycles after the scan settles; there is no backpressure, and all strobes are one-cycle pulses.
module keypad_entry #(
    parameter int  DIGITS   = 3,
    parameter int  DEBOUNCE = 4,
    localparam int CW       = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    keypad_entry_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] LAST  = SW'(DEBOUNCE - 1);
    localparam logic [W-1:0]  BLANK = '1;

    typedef enum logic [1:0] {IDLE, ARM, HELD} state_t;

    state_t        state;
    logic [15:0]   onehot_q;
    logic [3:0]    cand;
    logic [SW-1:0] stable;
    logic [W-1:0]  bcd;
    logic [CW-1:0] count;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          entry_valid;
    logic          overflow;
    logic          done;

    logic          dec_vld;
    logic [3:0]    dec_code;
    logic          accept;

    assign bus.bcd         = bcd;
    assign bus.count       = count;
    assign bus.key_code    = key_code;
    assign bus.key_valid   = key_valid;
    assign bus.entry_valid = entry_valid;
    assign bus.overflow    = overflow;

    // Only the keypad's wired positions decode; spare columns and multi-hot scans are NONE.
    always_comb begin
        dec_vld  = 1'b1;
        dec_code = 4'h0;
        case (onehot_q)
            16'h0008: dec_code = 4'd0;
            16'h0080: dec_code = 4'd1;
            16'h0040: dec_code = 4'd2;
            16'h0020: dec_code = 4'd3;
            16'h0800: dec_code = 4'd4;
            16'h0400: dec_code = 4'd5;
            16'h0200: dec_code = 4'd6;
            16'h8000: dec_code = 4'd7;
            16'h4000: dec_code = 4'd8;
            16'h2000: dec_code = 4'd9;
            16'h0001: dec_code = 4'hC;
            16'h0002: dec_code = 4'hB;
            16'h0004: dec_code = 4'hE;
            default:  dec_vld  = 1'b0;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        case (state)
            IDLE:    accept = dec_vld && (DEBOUNCE == 1);
            ARM:     accept = dec_vld && (dec_code == cand) && (stable == LAST);
            default: accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            onehot_q    <= '0;
            cand        <= '0;
            stable      <= '0;
            bcd         <= BLANK;
            count       <= '0;
            key_code    <= 4'hF;
            key_valid   <= 1'b0;
            entry_valid <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            onehot_q    <= bus.onehot;
            key_valid   <= 1'b0;
            entry_valid <= 1'b0;
            overflow    <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= HELD;
                        stable <= '0;
                    end else if (dec_vld) begin
                        state  <= ARM;
                        cand   <= dec_code;
                        stable <= SW'(1);
                    end
                end
                ARM: begin
                    if (accept) begin
                        state  <= HELD;
                        stable <= '0;
                    end else if (!dec_vld || dec_code != cand) begin
                        state <= IDLE;
                    end else begin
                        stable <= stable + 1'b1;
                    end
                end
                default: begin
                    // Counts consecutive NONE samples; any key activity restarts the release window.
                    if (dec_vld) begin
                        stable <= '0;
                    end else if (stable == LAST) begin
                        state  <= IDLE;
                        stable <= '0;
                    end else begin
                        stable <= stable + 1'b1;
                    end
                end
            endcase

            if (accept) begin
                key_code  <= dec_code;
                key_valid <= 1'b1;
                if (dec_code <= 4'd9) begin
                    if (done) begin
                        bcd   <= (BLANK << 4) | W'(dec_code);
                        count <= CW'(1);
                        done  <= 1'b0;
                    end else if (count == CW'(DIGITS)) begin
                        overflow <= 1'b1;
                    end else begin
                        bcd   <= (bcd << 4) | W'(dec_code);
                        count <= count + 1'b1;
                    end
                end else if (dec_code == 4'hB) begin
                    done <= 1'b0;
                    if (count != '0) begin
                        bcd   <= (bcd >> 4) | ~(BLANK >> 4);
                        count <= count - 1'b1;
                    end
                end else if (dec_code == 4'hC) begin
                    bcd   <= BLANK;
                    count <= '0;
                    done  <= 1'b0;
                end else if (count != '0) begin
                    entry_valid <= 1'b1;
                    done        <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Parametrised keypad digit-entry engine: decodes the 16-bit one-hot keypad scan, debounces each press, and assembles a multi-digit BCD number with clear, backspace and enter keys. It sits between the keypad scanner and the seven-segment display/consumer logic. It replaces fixed three-digit capture with configurable depth, press/release debouncing, editing keys and a completed-entry strobe.

## Interface
- DIGITS, 3: number of BCD digits held; must be ≥ 1
- DEBOUNCE, 4: consecutive identical samples required to accept a press or a release; must be ≥ 1
- CW, $clog2(DIGITS+1): width of `count`; derived, do not override

- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- onehot  in  16  keypad scan code, one-hot or zero
- bcd  out  4*DIGITS  entered number; digit 0 (least significant, most recent) in [3:0]; unused digits read 4'hF (blank)
- count  out  CW  digits currently entered, 0..DIGITS
- key_code  out  4  code of the last accepted key
- key_valid  out  1  one-cycle pulse per accepted key
- entry_valid  out  1  one-cycle pulse when ENTER accepted with count > 0
- overflow  out  1  one-cycle pulse when a digit is rejected because count == DIGITS

## Operation
- Input stage: `onehot_q <= onehot` every cycle. Decode uses only `onehot_q`.
- Key map (decoded code): 0x0008→0, 0x0080→1, 0x0040→2, 0x0020→3, 0x0800→4, 0x0400→5, 0x0200→6, 0x8000→7, 0x4000→8, 0x2000→9, 0x0001→CLEAR (4'hC), 0x0002→BACKSPACE (4'hB), 0x0004→ENTER (4'hE). 0x0010, 0x0100, 0x1000, zero, and any multi-hot value decode as NONE.
- FSM states:
  - IDLE: decoded key valid → ARM, capture candidate, stable count = 1.
  - ARM: decoded ≠ candidate (including NONE) → IDLE, no action. Decoded = candidate and DEBOUNCE samples reached → accept: apply action, pulse key_valid, go to HELD.
  - HELD: no further keys accepted (no auto-repeat). DEBOUNCE consecutive NONE samples → IDLE; any non-NONE sample restarts the release count.
  - DEBOUNCE = 1: accept directly from IDLE.
- Actions on accept:
  - Digit d, count < DIGITS: bcd <= {bcd[4*DIGITS-5:0], d}; count++.
  - Digit, count == DIGITS: bcd/count unchanged; overflow pulses.
  - Digit while `done` flag set: bcd <= all F except digit0 = d; count = 1; done cleared.
  - BACKSPACE: count > 0 → bcd <= {4'hF, bcd[4*DIGITS-1:4]}, count--; count == 0 → no change. Clears done.
  - CLEAR: bcd <= all F, count <= 0, done cleared.
  - ENTER: count > 0 → entry_valid pulses, done set, bcd/count held; count == 0 → ignored (key_valid still pulses).
- key_code updates on every accept, including rejected digits and ignored ENTER.

## Timing
- Reset (async): bcd = all 4'hF, count = 0, key_code = 4'hF, key_valid = entry_valid = overflow = 0, done = 0, onehot_q = 0, FSM = IDLE.
- Press latency: onehot stable before edge 1 → bcd, count, key_code and pulses update at edge DEBOUNCE+1 (edge 5 with default).
- Pulses are exactly one cycle and coincide with the bcd/count update.
- Release: FSM reaches IDLE at edge DEBOUNCE+1 after the first NONE sample; a new press is sampled from that point.
- Glitch shorter than DEBOUNCE samples: no output change.
- Reset asserted mid-ARM or mid-HELD: immediate return to reset values; a key still held after reset deasserts is treated as a new press.

## Test plan
- Reset, then press 0x0080 (1), 0x0040 (2), 0x0020 (3), each held 8 cycles with 8-cycle gaps → bcd = 12'h123, count = 3, three key_valid pulses, first at edge 5.
- DIGITS=3 full, press 0x0800 (4) → overflow pulse, bcd stays 12'h123, key_code = 4.
- bcd 12'h123: BACKSPACE (0x0002) → 12'hF12, count 2; CLEAR (0x0001) → 12'hFFF, count 0.
- Enter "7","8" then ENTER (0x0004) → entry_valid pulse, bcd 12'hF78; next press 0x2000 (9) → bcd 12'hFF9, count 1. ENTER with count 0 → no entry_valid.
- 3-cycle pulse of 0x0008, multi-hot 0x0088, and 0x0010 → no key_valid, bcd unchanged; key held 50 cycles → exactly one key_valid.
- DIGITS=5, DEBOUNCE=1: enter 1-2-3-4-5 → bcd 20'h12345, count 5, each update at edge 2 after press; rst asserted mid-hold → bcd = 20'hFFFFF immediately.
